// File: rtl/tnn_frontend_pkg.sv
// rtl/tnn_frontend_pkg.sv - shared constants and types for the TNN feature front-end
//
// Purpose: frame geometry, quantizer widths, threshold reset values and the
// loader FSM state type, shared by the quantizer and the frame loader.
package tnn_frontend_pkg;

  localparam int N_FEAT = 7;
  localparam int RAW_W  = 8;
  localparam int CODE_W = 2;
  localparam int IDX_W  = 5;
  localparam int N_THR  = N_FEAT * 3;

  // Sized copies used in comparisons so widths match exactly.
  localparam logic [IDX_W-1:0] THR_COUNT = IDX_W'(N_THR);
  localparam logic [2:0]       LAST_SLOT = 3'(N_FEAT - 1);

  localparam logic [RAW_W-1:0] THR0 = 8'd64;
  localparam logic [RAW_W-1:0] THR1 = 8'd128;
  localparam logic [RAW_W-1:0] THR2 = 8'd192;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRESENT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/tnn_feature_quantizer.sv
// rtl/tnn_feature_quantizer.sv - combinational 3-threshold thermometer-count quantizer
//
// Purpose: maps one raw unsigned sample to a 2-bit code equal to the number of
// thresholds it meets or exceeds. Thresholds are not assumed to be ordered.
// Ports:
//   i_data  raw sample
//   i_thr0  threshold 0
//   i_thr1  threshold 1
//   i_thr2  threshold 2
//   o_code  count of thresholds with i_data >= threshold (0..3)
module tnn_feature_quantizer
  import tnn_frontend_pkg::*;
(
  input  logic [RAW_W-1:0]  i_data,
  input  logic [RAW_W-1:0]  i_thr0,
  input  logic [RAW_W-1:0]  i_thr1,
  input  logic [RAW_W-1:0]  i_thr2,
  output logic [CODE_W-1:0] o_code
);

  logic w_ge0;
  logic w_ge1;
  logic w_ge2;

  assign w_ge0  = (i_data >= i_thr0);
  assign w_ge1  = (i_data >= i_thr1);
  assign w_ge2  = (i_data >= i_thr2);
  assign o_code = {1'b0, w_ge0} + {1'b0, w_ge1} + {1'b0, w_ge2};

endmodule

// File: rtl/tnn_feature_frame_loader.sv
// rtl/tnn_feature_frame_loader.sv - quantizes a raw feature stream into held 7-code frames
//
// Purpose: accepts serial 8-bit samples, quantizes each against per-feature
// programmable thresholds, assembles 7 codes and holds the frame stable on a
// valid/ready output for the combinational TNN neuron.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        raw sample handshake
//   in_data, in_last         raw sample, end-of-frame marker
//   thr_wr_en/idx/data       threshold write port (idx = feature*3 + k)
//   frame_valid/frame_ready  frame handshake
//   frame_codes              feature k at bits [2k+1:2k]
//   frame_err                one-cycle pulse on a framing error
module tnn_feature_frame_loader
  import tnn_frontend_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RAW_W-1:0]         in_data,
  input  logic                     in_last,
  input  logic                     thr_wr_en,
  input  logic [IDX_W-1:0]         thr_wr_idx,
  input  logic [RAW_W-1:0]         thr_wr_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [N_FEAT*CODE_W-1:0] frame_codes,
  output logic                     frame_err
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [2:0]                r_idx;
  logic [N_FEAT*CODE_W-1:0]  r_slots;
  logic [N_FEAT*CODE_W-1:0]  r_frame_codes;
  logic                      r_frame_valid;
  logic                      r_frame_err;
  logic [RAW_W-1:0]          r_thr [0:N_THR-1];

  logic                      w_accept;
  logic                      w_done;
  logic                      w_err;
  logic [IDX_W-1:0]          w_thr_base;
  logic [CODE_W-1:0]         w_code;
  logic [N_FEAT*CODE_W-1:0]  w_frame_next;

  // in_ready is forced low while rst is asserted so no beat is taken in the reset cycle.
  assign in_ready    = ~rst && (r_state != PRESENT);
  assign w_accept    = in_valid && in_ready;
  assign frame_valid = r_frame_valid;
  assign frame_codes = r_frame_codes;
  assign frame_err   = r_frame_err;

  // Quantize against the current slot's thresholds; a same-cycle write is not yet visible.
  assign w_thr_base = {2'b00, r_idx} * 5'd3;

  tnn_feature_quantizer u_quant (
    .i_data (in_data),
    .i_thr0 (r_thr[w_thr_base]),
    .i_thr1 (r_thr[w_thr_base + 5'd1]),
    .i_thr2 (r_thr[w_thr_base + 5'd2]),
    .o_code (w_code)
  );

  always_comb begin
    w_frame_next = r_slots;
    w_frame_next[{r_idx, 1'b0} +: CODE_W] = w_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (in_last) begin
            if (r_idx == LAST_SLOT) begin
              w_done       = 1'b1;
              w_next_state = PRESENT;
            end else begin
              w_err = 1'b1;
            end
          end else if (r_idx == LAST_SLOT) begin
            // Seventh beat without in_last: flush the rest of this frame.
            w_err        = 1'b1;
            w_next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_accept && in_last) begin
          w_next_state = COLLECT;
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          w_next_state = COLLECT;
        end
      end
      default: w_next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= 3'd0;
      r_slots       <= '0;
      r_frame_codes <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      for (int i = 0; i < N_THR; i++) begin
        if ((i % 3) == 0)      r_thr[i] <= THR0;
        else if ((i % 3) == 1) r_thr[i] <= THR1;
        else                   r_thr[i] <= THR2;
      end
    end else begin
      r_frame_err <= w_err;
      if (thr_wr_en && (thr_wr_idx < THR_COUNT)) begin
        r_thr[thr_wr_idx] <= thr_wr_data;
      end
      if ((r_state == COLLECT) && w_accept) begin
        if (in_last || (r_idx == LAST_SLOT)) begin
          r_idx <= 3'd0;
        end else begin
          r_idx   <= r_idx + 3'd1;
          r_slots <= w_frame_next;
        end
      end
      if (w_done) begin
        r_frame_codes <= w_frame_next;
        r_frame_valid <= 1'b1;
      end else if ((r_state == PRESENT) && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

endmodule
